// File: rtl/mac_array_if.sv
// Handshake bundle for mac_array: beat input (in_valid/in_ready/a/b/klen),
// result output (out_valid/out_ready/y) and busy. master = producer/consumer, slave = mac_array.
interface mac_array_if #(
   parameter int I_W    = 8,
   parameter int LANES  = 4,
   parameter int KLEN_W = 8
);
   localparam int ACC_W = 2*I_W + $clog2(LANES) + KLEN_W;

   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*I_W-1:0]     a;
   logic [LANES*I_W-1:0]     b;
   logic [KLEN_W-1:0]        klen;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  y;
   logic                     busy;

   modport master (
      output in_valid, a, b, klen, out_ready,
      input  in_ready, out_valid, y, busy
   );

   modport slave (
      input  in_valid, a, b, klen, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/mac_array.sv
// Pipelined signed dot-product accumulator over windows of klen beats.
// Ports: clk, rst (sync active-high), clr (sync flush), bus (mac_array_if.slave).
// Define MAC_ARRAY_RELU_EN to clamp negative results to zero on y.
module mac_array #(
   parameter int I_W    = 8,
   parameter int LANES  = 4,
   parameter int KLEN_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   mac_array_if.slave bus
);
   localparam int P_W   = 2*I_W;
   localparam int SUM_W = P_W + $clog2(LANES);
   localparam int ACC_W = SUM_W + KLEN_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACC   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]              state;
   logic [1:0]              fcnt;
   logic [KLEN_W-1:0]       count;
   logic [KLEN_W-1:0]       klen_q;
   logic [KLEN_W-1:0]       klen_eff;
   logic signed [P_W-1:0]   prod_d [LANES];
   logic signed [P_W-1:0]   prod_q [LANES];
   logic signed [SUM_W-1:0] sum_d;
   logic signed [SUM_W-1:0] sum_q;
   logic signed [ACC_W-1:0] acc;
   logic                    take;
   logic                    flush;
   logic                    done;

   assign flush         = rst || clr;
   assign bus.in_ready  = (state == IDLE) || (state == ACC);
   assign take          = bus.in_valid && bus.in_ready;
   assign done          = (state == HOLD) && bus.out_ready;
   assign klen_eff      = (bus.klen == '0) ? KLEN_W'(1) : bus.klen;
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == HOLD);

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         prod_d[k] = P_W'($signed(bus.a[k*I_W +: I_W]))
                   * P_W'($signed(bus.b[k*I_W +: I_W]));
      end
   end

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < LANES; k++) begin
         sum_d = sum_d + SUM_W'(prod_q[k]);
      end
   end

   // Gap cycles load zero products so the accumulator sees nothing.
   always_ff @(posedge clk) begin
      if (flush) begin
         for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
         sum_q <= '0;
         acc   <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            prod_q[k] <= take ? prod_d[k] : '0;
         end
         sum_q <= sum_d;
         if (done) acc <= '0;
         else      acc <= acc + ACC_W'(sum_q);
      end
   end

   // FLUSH covers the three pipeline stages behind the last beat.
   always_ff @(posedge clk) begin
      if (flush) begin
         state  <= IDLE;
         count  <= '0;
         klen_q <= '0;
         fcnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  klen_q <= klen_eff;
                  count  <= KLEN_W'(1);
                  fcnt   <= '0;
                  state  <= (klen_eff == KLEN_W'(1)) ? FLUSH : ACC;
               end
            end
            ACC: begin
               if (take) begin
                  count <= count + KLEN_W'(1);
                  if (count + KLEN_W'(1) == klen_q) state <= FLUSH;
               end
            end
            FLUSH: begin
               fcnt <= fcnt + 2'd1;
               if (fcnt == 2'd2) state <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state <= IDLE;
                  count <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.y = '0;
      if (state == HOLD) begin
`ifdef MAC_ARRAY_RELU_EN
         bus.y = acc[ACC_W-1] ? '0 : acc;
`else
         bus.y = acc;
`endif
      end
   end
endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array with a result scoreboard.
// Expected window sums are queued at window close and popped when out_valid rises.
module tb_mac_array;
   localparam int I_W    = 8;
   localparam int LANES  = 4;
   localparam int KLEN_W = 8;

   logic clk = 1'b0;
   logic rst;
   logic clr;

   int errors = 0;
   int checks = 0;
   logic signed [63:0] sb [$];
   logic signed [63:0] model_acc;
   logic signed [63:0] last_exp;

   always #5 clk = ~clk;

   mac_array_if #(.I_W(I_W), .LANES(LANES), .KLEN_W(KLEN_W)) bus ();

   mac_array #(.I_W(I_W), .LANES(LANES), .KLEN_W(KLEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic signed [63:0] obs,
                      logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(int v0, int v1, int v2, int v3);
      logic [31:0] r;
      r[7:0]   = v0[7:0];
      r[15:8]  = v1[7:0];
      r[23:16] = v2[7:0];
      r[31:24] = v3[7:0];
      return r;
   endfunction

   function automatic logic signed [63:0] shape(logic signed [63:0] v);
`ifdef MAC_ARRAY_RELU_EN
      return (v < 0) ? 64'sd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic beat(string tag, int a0, int a1, int a2, int a3,
                       int b0, int b1, int b2, int b3, int kl);
      bus.in_valid = 1'b1;
      bus.a        = pk(a0, a1, a2, a3);
      bus.b        = pk(b0, b1, b2, b3);
      bus.klen     = KLEN_W'(kl);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      model_acc += a0*b0 + a1*b1 + a2*b2 + a3*b3;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic close_window();
      sb.push_back(shape(model_acc));
      model_acc = 0;
   endtask

   task automatic expect_out(string tag);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk({tag, "_early"}, bus.out_valid, 0);
      end
      tick();
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_rdy_low"}, bus.in_ready, 0);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s_sb: observed=empty expected=entry", tag);
      end else begin
         last_exp = sb.pop_front();
         chk({tag, "_y"}, bus.y, last_exp);
      end
   endtask

   task automatic consume(string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_ov0"}, bus.out_valid, 0);
      chk({tag, "_y0"}, bus.y, 0);
      chk({tag, "_idle"}, bus.busy, 0);
      chk({tag, "_rdy1"}, bus.in_ready, 1);
   endtask

   task automatic idle_outputs(string tag);
      chk({tag, "_ov"}, bus.out_valid, 0);
      chk({tag, "_y"}, bus.y, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_rdy"}, bus.in_ready, 1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.klen      = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      clr           = 1'b0;
      model_acc     = 0;
      last_exp      = 0;
      tick();
      tick();
      rst = 1'b0;
      idle_outputs("reset");

      beat("w70", 1, 2, 3, 4, 5, 6, 7, 8, 1);
      close_window();
      expect_out("w70");
      consume("w70");

      beat("gap_b1", 1, 1, 1, 1, 1, 1, 1, 1, 3);
      chk("gap_rdy", bus.in_ready, 1);
      chk("gap_busy", bus.busy, 1);
      tick();
      beat("gap_b2", 1, 1, 1, 1, 1, 1, 1, 1, 3);
      beat("gap_b3", 1, 1, 1, 1, 1, 1, 1, 1, 3);
      close_window();
      expect_out("gap");

      bus.in_valid = 1'b1;
      bus.a        = pk(9, 9, 9, 9);
      bus.b        = pk(9, 9, 9, 9);
      bus.klen     = 8'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_ov", bus.out_valid, 1);
         chk("hold_y", bus.y, last_exp);
         chk("hold_rdy", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      consume("hold");

      beat("fresh", 2, 0, 0, 0, 3, 0, 0, 0, 1);
      close_window();
      expect_out("fresh");
      consume("fresh");

      beat("neg", -1, -2, 3, -4, 5, 6, -7, 8, 1);
      close_window();
      expect_out("neg");
      consume("neg");

      beat("k0", 1, 1, 1, 1, 2, 2, 2, 2, 0);
      close_window();
      expect_out("k0");
      consume("k0");

      beat("klat_b1", 3, -3, 2, 1, 4, 5, -6, 7, 2);
      beat("klat_b2", 1, 1, 1, 1, 10, 20, 30, 40, 7);
      close_window();
      expect_out("klat");
      consume("klat");

      for (int i = 0; i < 255; i++) begin
         beat("ext", -128, -128, -128, -128, -128, -128, -128, -128, 255);
      end
      close_window();
      expect_out("ext");
      chk("ext_const", bus.y, 64'sd16711680);
      consume("ext");

      beat("clr_b1", 1, 1, 1, 1, 1, 1, 1, 1, 4);
      bus.in_valid = 1'b1;
      bus.a        = pk(5, 5, 5, 5);
      bus.b        = pk(5, 5, 5, 5);
      clr          = 1'b1;
      tick();
      clr          = 1'b0;
      bus.in_valid = 1'b0;
      model_acc    = 0;
      idle_outputs("clr");
      beat("after_clr", 1, 0, 0, 0, -3, 0, 0, 0, 1);
      close_window();
      expect_out("after_clr");
      consume("after_clr");

      beat("rst_hold", 2, 2, 2, 2, 2, 2, 2, 2, 1);
      close_window();
      expect_out("rst_hold");
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      rst           = 1'b0;
      bus.out_ready = 1'b0;
      idle_outputs("rst_hold_post");
      beat("post_rst", 1, 2, 0, 0, 1, 1, 0, 0, 1);
      close_window();
      expect_out("post_rst");
      consume("post_rst");

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 Parameter I_W, default 8, signed operand width per lane.
REQ-002 Parameter LANES, default 4, parallel multiplier lanes (power of two, 1..16).
REQ-003 Parameter KLEN_W, default 8, width of beat-count input klen.
REQ-004 Derived ACC_W = 2*I_W + clog2(LANES) + KLEN_W; accumulator and result width.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clr  input  1  synchronous flush; aborts any window in progress.
REQ-008 in_valid  input  1  a/b/klen valid this cycle.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 a  input  LANES*I_W  packed signed operands, lane k at bits [k*I_W +: I_W].
REQ-011 b  input  LANES*I_W  packed signed operands, same packing.
REQ-012 klen  input  KLEN_W  beats per window, sampled on first beat only; 0 treated as 1.
REQ-013 out_valid  output  1  y holds a completed window result.
REQ-014 out_ready  input  1  consumer accepts y.
REQ-015 y  output  ACC_W  signed dot-product sum over the window.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 Beat accepted when in_valid && in_ready; per beat, sum over lanes of a[k]*b[k], full signed precision, no truncation.
REQ-018 Pipeline: stage 1 registers LANES products; stage 2 registers lane-sum; stage 3 adds into accumulator.
REQ-019 FSM states IDLE, ACC, FLUSH, HOLD; IDLE->ACC on first accepted beat (klen latched, count=1); ACC->FLUSH when the klen-th beat is accepted (IDLE->FLUSH directly if latched klen<=1).
REQ-020 FLUSH lasts exactly 3 cycles draining the pipeline, then HOLD with out_valid=1.
REQ-021 Latency: out_valid rises on the 3rd rising edge after the edge accepting the last beat.
REQ-022 in_ready = 1 in IDLE and ACC, 0 in FLUSH and HOLD.
REQ-023 Beats with in_valid=0 in ACC are gaps: count and accumulator unchanged, pipeline carries zero.
REQ-024 HOLD: y and out_valid stable until out_valid && out_ready; on that edge out_valid=0, accumulator cleared, state->IDLE.
REQ-025 Accumulator cannot overflow by construction of ACC_W; no wrap logic required.
REQ-026 clr=1: same effect as rst on the following edge; in-flight beat and any unconsumed result discarded; clr overrides simultaneous in_valid/out_ready.
REQ-027 y = 0 whenever out_valid = 0.

Reset
REQ-028 On rst=1 at a rising edge: state IDLE, count 0, pipeline regs and accumulator 0, y=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-029 rst has priority over clr and all handshakes; reset mid-window discards the window.

Configuration
REQ-030 Macro MAC_ARRAY_RELU_EN defined: y = max(result, 0) when presented; negative results output as 0 with out_valid still asserted.
REQ-031 Macro undefined: y = raw signed accumulator; no clamp logic synthesised.

Verification
REQ-032 LANES=4, klen=1, a={1,2,3,4}, b={5,6,7,8} -> out_valid 3 cycles after acceptance, y=70.
REQ-033 klen=3, beats a=b={1,1,1,1} with one in_valid=0 gap after beat 1 -> y=12, out_valid after 3rd beat+3; in_ready low from FLUSH until handshake.
REQ-034 Result held with out_ready=0 for 5 cycles -> y and out_valid stable; in_valid ignored; accepted on out_ready=1, next window starts from 0.
REQ-035 Extremes: I_W=8, klen=255, all a=b=-128 -> y = 255*4*16384 = 16711680, no overflow.
REQ-036 clr asserted during 2nd beat of klen=4 window -> next cycle IDLE, out_valid=0; fresh klen=1 window a={1,0,0,0}, b={-3,0,0,0} yields -3 (0 with MAC_ARRAY_RELU_EN).
REQ-037 rst asserted in HOLD with out_ready=1 same cycle -> no handshake counted, all outputs 0, busy=0.
